// File: rtl/fft_in_reorder.sv
// Input reorder stage for the 8-point real FFT: ping-pong frame buffer that
// replays each completed frame as four bit-reversed sample pairs.
module fft_in_reorder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_en,
  output logic [DATA_W-1:0] out_x0,
  output logic [DATA_W-1:0] out_x1,
  output logic [1:0]        out_pair_idx,
  output logic              out_last,
  output logic              sync_err
);

  localparam int unsigned    PtrW    = 3;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(N - 1);

  typedef enum logic [0:0] {StIdle, StRd} state_e;

  // Buffer storage is not reset; its contents are don't-care until written.
  logic [DATA_W-1:0] mem_q [2][N];

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic            wbank_q, wbank_d;
  logic [1:0]      full_q, full_d;
  logic            sync_err_q, sync_err_d;

  state_e          state_q, state_d;
  logic            rbank_q, rbank_d;
  logic [1:0]      pair_q, pair_d;

  logic              out_en_q, out_en_d;
  logic [DATA_W-1:0] out_x0_q, out_x0_d;
  logic [DATA_W-1:0] out_x1_q, out_x1_d;
  logic [1:0]        out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;

  logic            wr_en, resync, frame_done;
  logic [PtrW-1:0] wr_addr;

  logic            emit, clr_full, emit_bank, other_bank;
  logic [1:0]      emit_pair;
  logic [PtrW-1:0] rd_addr0, rd_addr1;

  // Write side: sof mid-frame restarts the same bank at index 0.
  always_comb begin
    wr_en      = en & in_valid;
    resync     = wr_en & in_sof & (wptr_q != '0);
    frame_done = wr_en & ~resync & (wptr_q == LastPtr);
    wr_addr    = resync ? '0 : wptr_q;

    wptr_d     = wptr_q;
    wbank_d    = wbank_q;
    sync_err_d = sync_err_q | resync;
    if (resync) begin
      wptr_d = PtrW'(1);
    end else if (frame_done) begin
      wptr_d  = '0;
      wbank_d = ~wbank_q;
    end else if (wr_en) begin
      wptr_d = wptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wbank_q][wr_addr] <= in_data;
    end
  end

  // Read FSM: IDLE emits pair 0 on the same edge it claims a bank, so pair 0
  // lands one edge after the frame completes.
  always_comb begin
    state_d    = state_q;
    rbank_d    = rbank_q;
    pair_d     = pair_q;
    emit       = 1'b0;
    clr_full   = 1'b0;
    emit_bank  = rbank_q;
    emit_pair  = pair_q;
    other_bank = ~rbank_q;

    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (|full_q) begin
            emit      = 1'b1;
            emit_bank = ~full_q[0];
            emit_pair = 2'd0;
            rbank_d   = ~full_q[0];
            pair_d    = 2'd1;
            state_d   = StRd;
          end
        end
        StRd: begin
          emit = 1'b1;
          if (pair_q == 2'd3) begin
            clr_full = 1'b1;
            if (full_q[other_bank]) begin
              rbank_d = other_bank;
              pair_d  = 2'd0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            pair_d = pair_q + 2'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Flags: the bank being cleared is never the bank being completed.
  always_comb begin
    full_d = full_q;
    if (clr_full) begin
      full_d[rbank_q] = 1'b0;
    end
    if (frame_done) begin
      full_d[wbank_q] = 1'b1;
    end
  end

  // Pair k reads x[rev(k)] and x[rev(k)+4], rev being the 2-bit reversal.
  always_comb begin
    rd_addr0 = {1'b0, emit_pair[0], emit_pair[1]};
    rd_addr1 = {1'b1, emit_pair[0], emit_pair[1]};

    out_en_d   = out_en_q;
    out_x0_d   = out_x0_q;
    out_x1_d   = out_x1_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    if (en) begin
      if (emit) begin
        out_en_d   = 1'b1;
        out_x0_d   = mem_q[emit_bank][rd_addr0];
        out_x1_d   = mem_q[emit_bank][rd_addr1];
        out_idx_d  = emit_pair;
        out_last_d = (emit_pair == 2'd3);
      end else begin
        out_en_d   = 1'b0;
        out_last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      wbank_q    <= 1'b0;
      full_q     <= '0;
      sync_err_q <= 1'b0;
      state_q    <= StIdle;
      rbank_q    <= 1'b0;
      pair_q     <= 2'd0;
      out_en_q   <= 1'b0;
      out_x0_q   <= '0;
      out_x1_q   <= '0;
      out_idx_q  <= 2'd0;
      out_last_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      wbank_q    <= wbank_d;
      full_q     <= full_d;
      sync_err_q <= sync_err_d;
      state_q    <= state_d;
      rbank_q    <= rbank_d;
      pair_q     <= pair_d;
      out_en_q   <= out_en_d;
      out_x0_q   <= out_x0_d;
      out_x1_q   <= out_x1_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_en       = out_en_q;
  assign out_x0       = out_x0_q;
  assign out_x1       = out_x1_q;
  assign out_pair_idx = out_idx_q;
  assign out_last     = out_last_q;
  assign sync_err     = sync_err_q;

  // Full-rate input cannot lap the drain; writing a still-full bank is a bug.
  a_no_overwrite: assert property (@(posedge clk) disable iff (!reset_n)
    (en && in_valid) |-> !full_q[wbank_q]);

endmodule

// File: tb/tb_fft_in_reorder.sv
// Directed bench for fft_in_reorder: table-driven frame streams plus
// hand-written enable-stall and asynchronous-reset sequences.
module tb_fft_in_reorder;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        in_valid;
  logic        in_sof;
  logic [15:0] in_data;
  logic        out_en;
  logic [15:0] out_x0;
  logic [15:0] out_x1;
  logic [1:0]  out_pair_idx;
  logic        out_last;
  logic        sync_err;

  fft_in_reorder #(
    .DATA_W(16),
    .N     (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_data     (in_data),
    .out_en      (out_en),
    .out_x0      (out_x0),
    .out_x1      (out_x1),
    .out_pair_idx(out_pair_idx),
    .out_last    (out_last),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        vld;
    logic        sof;
    logic [15:0] data;
    logic        exp_en;
    logic        exp_last;
    logic        exp_err;
    logic        chk_data;
    logic [1:0]  exp_idx;
    logic [15:0] exp_x0;
    logic [15:0] exp_x1;
  } vec_t;

  vec_t tbl [64];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rev2(input int k);
    case (k)
      0: return 16'd0;
      1: return 16'd2;
      2: return 16'd1;
      default: return 16'd3;
    endcase
  endfunction

  task automatic clear_tbl(input logic err);
    for (int i = 0; i < 64; i++) begin
      tbl[i].en       = 1'b1;
      tbl[i].vld      = 1'b0;
      tbl[i].sof      = 1'b0;
      tbl[i].data     = 16'h0;
      tbl[i].exp_en   = 1'b0;
      tbl[i].exp_last = 1'b0;
      tbl[i].exp_err  = err;
      tbl[i].chk_data = 1'b0;
      tbl[i].exp_idx  = 2'd0;
      tbl[i].exp_x0   = 16'h0;
      tbl[i].exp_x1   = 16'h0;
    end
  endtask

  task automatic set_in(input int i, input logic sof, input logic [15:0] d);
    tbl[i].vld  = 1'b1;
    tbl[i].sof  = sof;
    tbl[i].data = d;
  endtask

  task automatic set_pair(input int i, input int k, input logic [15:0] base);
    tbl[i].exp_en   = 1'b1;
    tbl[i].exp_last = (k == 3);
    tbl[i].chk_data = 1'b1;
    tbl[i].exp_idx  = 2'(k);
    tbl[i].exp_x0   = base + rev2(k);
    tbl[i].exp_x1   = base + 16'd4 + rev2(k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tname, input int len);
    for (int i = 0; i < len; i++) begin
      en       = tbl[i].en;
      in_valid = tbl[i].vld;
      in_sof   = tbl[i].sof;
      in_data  = tbl[i].data;
      step();
      chk($sformatf("%s[%0d].out_en", tname, i), 32'(out_en), 32'(tbl[i].exp_en));
      chk($sformatf("%s[%0d].out_last", tname, i), 32'(out_last), 32'(tbl[i].exp_last));
      chk($sformatf("%s[%0d].sync_err", tname, i), 32'(sync_err), 32'(tbl[i].exp_err));
      if (tbl[i].chk_data) begin
        chk($sformatf("%s[%0d].out_x0", tname, i), 32'(out_x0), 32'(tbl[i].exp_x0));
        chk($sformatf("%s[%0d].out_x1", tname, i), 32'(out_x1), 32'(tbl[i].exp_x1));
        chk($sformatf("%s[%0d].idx", tname, i), 32'(out_pair_idx), 32'(tbl[i].exp_idx));
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic chk_pair(input string name, input int k, input logic [15:0] base);
    chk({name, ".out_en"}, 32'(out_en), 32'd1);
    chk({name, ".idx"}, 32'(out_pair_idx), 32'(k));
    chk({name, ".out_last"}, 32'(out_last), 32'(k == 3));
    chk({name, ".out_x0"}, 32'(out_x0), 32'(base + rev2(k)));
    chk({name, ".out_x1"}, 32'(out_x1), 32'(base + 16'd4 + rev2(k)));
  endtask

  // Feeds one frame with sof on x[0]; out_en must stay low throughout.
  task automatic feed_frame(input string name, input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      en       = 1'b1;
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_data  = base + 16'(i);
      step();
      chk($sformatf("%s.fill%0d.out_en", name, i), 32'(out_en), 32'd0);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 16'h0;
    #12;
    chk("reset.out_en", 32'(out_en), 32'd0);
    chk("reset.out_x0", 32'(out_x0), 32'd0);
    chk("reset.out_x1", 32'(out_x1), 32'd0);
    chk("reset.idx", 32'(out_pair_idx), 32'd0);
    chk("reset.out_last", 32'(out_last), 32'd0);
    chk("reset.sync_err", 32'(sync_err), 32'd0);
    #10;
    reset_n = 1'b1;

    // Single frame 10..17.
    clear_tbl(1'b0);
    for (int i = 0; i < 8; i++) set_in(i, (i == 0), 16'(10 + i));
    for (int k = 0; k < 4; k++) set_pair(8 + k, k, 16'd10);
    run_table("single", 13);

    // Three frames back-to-back at full rate.
    clear_tbl(1'b0);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) set_in(8 * f + i, (i == 0), 16'(100 * f + i));
      for (int k = 0; k < 4; k++) set_pair(8 * f + 8 + k, k, 16'(100 * f));
    end
    run_table("b2b", 29);

    // Gapped input with sign bit set.
    clear_tbl(1'b0);
    for (int i = 0; i < 8; i++) set_in(2 * i, (i == 0), 16'h8000 + 16'(i));
    for (int k = 0; k < 4; k++) set_pair(15 + k, k, 16'h8000);
    run_table("gapped", 20);

    // sof mid-frame: 40,41 discarded, 50..57 kept.
    clear_tbl(1'b0);
    set_in(0, 1'b1, 16'd40);
    set_in(1, 1'b0, 16'd41);
    set_in(2, 1'b1, 16'd50);
    for (int i = 1; i < 8; i++) set_in(2 + i, 1'b0, 16'(50 + i));
    for (int i = 2; i < 15; i++) tbl[i].exp_err = 1'b1;
    for (int k = 0; k < 4; k++) set_pair(10 + k, k, 16'd50);
    run_table("resync", 15);

    // en low for three cycles while pair 1 is on the outputs.
    feed_frame("stall", 16'd20);
    step();
    chk_pair("stall.p0", 0, 16'd20);
    step();
    chk_pair("stall.p1", 1, 16'd20);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_pair($sformatf("stall.hold%0d", i), 1, 16'd20);
    end
    en = 1'b1;
    step();
    chk_pair("stall.p2", 2, 16'd20);
    step();
    chk_pair("stall.p3", 3, 16'd20);
    step();
    chk("stall.done.out_en", 32'(out_en), 32'd0);
    chk("stall.done.out_last", 32'(out_last), 32'd0);
    chk("stall.done.x0_hold", 32'(out_x0), 32'd23);
    chk("stall.done.idx_hold", 32'(out_pair_idx), 32'd3);
    chk("stall.sync_err_sticky", 32'(sync_err), 32'd1);

    // Asynchronous reset in the middle of a drain.
    feed_frame("arst", 16'd30);
    step();
    chk_pair("arst.p0", 0, 16'd30);
    step();
    chk_pair("arst.p1", 1, 16'd30);
    step();
    chk_pair("arst.p2", 2, 16'd30);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst.out_en", 32'(out_en), 32'd0);
    chk("arst.out_x0", 32'(out_x0), 32'd0);
    chk("arst.out_x1", 32'(out_x1), 32'd0);
    chk("arst.idx", 32'(out_pair_idx), 32'd0);
    chk("arst.out_last", 32'(out_last), 32'd0);
    chk("arst.sync_err", 32'(sync_err), 32'd0);
    #7;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("arst.idle%0d.out_en", i), 32'(out_en), 32'd0);
    end
    feed_frame("fresh", 16'd60);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_pair($sformatf("fresh.p%0d", k), k, 16'd60);
    end
    step();
    chk("fresh.done.out_en", 32'(out_en), 32'd0);
    chk("fresh.sync_err", 32'(sync_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
